// File: rtl/cdb_broadcaster.sv
// Producer end of the common data bus: per-unit 2-entry result FIFOs, a round-robin
// arbiter over their heads, and one registered broadcast packet per cycle.
module cdb_broadcaster #(
   parameter int  NUM_FU  = 4,
   parameter int  XLEN    = 32,
   parameter int  ROB_LEN = 32,
   localparam int TAG_W   = $clog2(ROB_LEN),
   localparam int IDX_W   = $clog2(NUM_FU)
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    squash,
   input  logic [NUM_FU-1:0]       fu_valid,
   output logic [NUM_FU-1:0]       fu_ready,
   input  logic [NUM_FU*TAG_W-1:0] fu_tag,
   input  logic [NUM_FU*XLEN-1:0]  fu_value,
   input  logic [NUM_FU-1:0]       fu_wb_en,
   input  logic [NUM_FU-1:0]       fu_mispredict,
   output logic                    cdb_no_output,
   output logic [TAG_W-1:0]        cdb_tag,
   output logic                    cdb_tag_valid,
   output logic [XLEN-1:0]         cdb_value,
   output logic                    cdb_correct_predict,
   output logic [IDX_W-1:0]        cdb_grant
);

   logic [1:0]        cnt_q    [NUM_FU];
   logic [1:0]        cnt_d    [NUM_FU];
   logic [NUM_FU-1:0] wr_ptr_q, wr_ptr_d;
   logic [NUM_FU-1:0] rd_ptr_q, rd_ptr_d;
   logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;

   logic [TAG_W-1:0]  tag_mem_q [NUM_FU][2];
   logic [TAG_W-1:0]  tag_mem_d [NUM_FU][2];
   logic [XLEN-1:0]   val_mem_q [NUM_FU][2];
   logic [XLEN-1:0]   val_mem_d [NUM_FU][2];
   logic              wb_mem_q  [NUM_FU][2];
   logic              wb_mem_d  [NUM_FU][2];
   logic              mp_mem_q  [NUM_FU][2];
   logic              mp_mem_d  [NUM_FU][2];

   logic              no_output_q, no_output_d;
   logic [TAG_W-1:0]  tag_q, tag_d;
   logic              tag_valid_q, tag_valid_d;
   logic [XLEN-1:0]   value_q, value_d;
   logic              correct_predict_q, correct_predict_d;
   logic [IDX_W-1:0]  grant_q, grant_d;

   logic [NUM_FU-1:0] push, pop;
   logic              found;
   logic [IDX_W-1:0]  win, cand;

   // First non-empty FIFO scanning upward from rr_ptr; index arithmetic wraps at NUM_FU.
   always_comb begin : arbiter
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int off = 0; off < NUM_FU; off++) begin
         cand = rr_ptr_q + IDX_W'(off);
         if (!found && (cnt_q[cand] != 2'd0)) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   always_comb begin : handshake
      fu_ready = '0;
      push     = '0;
      pop      = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         fu_ready[i] = (cnt_q[i] < 2'd2);
         push[i]     = fu_valid[i] && fu_ready[i] && !squash;
         pop[i]      = found && (win == IDX_W'(i)) && !squash;
      end
   end

   always_comb begin : fifo_next
      tag_mem_d = tag_mem_q;
      val_mem_d = val_mem_q;
      wb_mem_d  = wb_mem_q;
      mp_mem_d  = mp_mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      for (int i = 0; i < NUM_FU; i++) begin
         cnt_d[i] = cnt_q[i];
         if (squash) begin
            cnt_d[i]    = 2'd0;
            wr_ptr_d[i] = 1'b0;
            rd_ptr_d[i] = 1'b0;
         end else begin
            if (push[i]) begin
               tag_mem_d[i][wr_ptr_q[i]] = fu_tag[i*TAG_W +: TAG_W];
               val_mem_d[i][wr_ptr_q[i]] = fu_value[i*XLEN +: XLEN];
               wb_mem_d[i][wr_ptr_q[i]]  = fu_wb_en[i];
               mp_mem_d[i][wr_ptr_q[i]]  = fu_mispredict[i];
               wr_ptr_d[i]               = ~wr_ptr_q[i];
            end
            if (pop[i]) begin
               rd_ptr_d[i] = ~rd_ptr_q[i];
            end
            case ({push[i], pop[i]})
               2'b10:   cnt_d[i] = cnt_q[i] + 2'd1;
               2'b01:   cnt_d[i] = cnt_q[i] - 2'd1;
               default: cnt_d[i] = cnt_q[i];
            endcase
         end
      end
   end

   always_comb begin : out_next
      no_output_d       = 1'b1;
      tag_d             = '0;
      tag_valid_d       = 1'b0;
      value_d           = '0;
      correct_predict_d = 1'b1;
      grant_d           = '0;
      rr_ptr_d          = rr_ptr_q;
      if (squash) begin
         rr_ptr_d = '0;
      end else if (found) begin
         no_output_d       = 1'b0;
         tag_d             = tag_mem_q[win][rd_ptr_q[win]];
         tag_valid_d       = wb_mem_q[win][rd_ptr_q[win]];
         value_d           = val_mem_q[win][rd_ptr_q[win]];
         correct_predict_d = !mp_mem_q[win][rd_ptr_q[win]];
         grant_d           = win;
         rr_ptr_d          = win + IDX_W'(1);
      end
   end

   // Control and broadcast register: reset forces the idle packet asynchronously.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_FU; i++) begin
            cnt_q[i] <= 2'd0;
         end
         wr_ptr_q          <= '0;
         rd_ptr_q          <= '0;
         rr_ptr_q          <= '0;
         no_output_q       <= 1'b1;
         tag_q             <= '0;
         tag_valid_q       <= 1'b0;
         value_q           <= '0;
         correct_predict_q <= 1'b1;
         grant_q           <= '0;
      end else begin
         cnt_q             <= cnt_d;
         wr_ptr_q          <= wr_ptr_d;
         rd_ptr_q          <= rd_ptr_d;
         rr_ptr_q          <= rr_ptr_d;
         no_output_q       <= no_output_d;
         tag_q             <= tag_d;
         tag_valid_q       <= tag_valid_d;
         value_q           <= value_d;
         correct_predict_q <= correct_predict_d;
         grant_q           <= grant_d;
      end
   end

   // FIFO payload storage is only ever read under a non-zero count, so it needs no reset.
   always_ff @(posedge clock) begin
      tag_mem_q <= tag_mem_d;
      val_mem_q <= val_mem_d;
      wb_mem_q  <= wb_mem_d;
      mp_mem_q  <= mp_mem_d;
   end

   assign cdb_no_output       = no_output_q;
   assign cdb_tag             = tag_q;
   assign cdb_tag_valid       = tag_valid_q;
   assign cdb_value           = value_q;
   assign cdb_correct_predict = correct_predict_q;
   assign cdb_grant           = grant_q;

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Bench for cdb_broadcaster: directed scenarios plus randomized traffic, checked
// against a queue-based model of the FIFOs and round-robin arbitration.
module tb_cdb_broadcaster;

   localparam int N  = 4;
   localparam int TW = 5;
   localparam int XW = 32;

   typedef struct packed {
      logic [TW-1:0] tag;
      logic [XW-1:0] val;
      logic          wb;
      logic          mp;
   } ent_t;

   localparam logic [41:0] IDLE = {1'b1, 5'd0, 1'b0, 32'd0, 1'b1, 2'd0};

   logic            clock = 1'b0;
   logic            reset;
   logic            squash;
   logic [N-1:0]    fu_valid;
   logic [N-1:0]    fu_ready;
   logic [N*TW-1:0] fu_tag;
   logic [N*XW-1:0] fu_value;
   logic [N-1:0]    fu_wb_en;
   logic [N-1:0]    fu_mispredict;
   logic            cdb_no_output;
   logic [TW-1:0]   cdb_tag;
   logic            cdb_tag_valid;
   logic [XW-1:0]   cdb_value;
   logic            cdb_correct_predict;
   logic [1:0]      cdb_grant;

   logic [TW-1:0]   tag_in [N];
   logic [XW-1:0]   val_in [N];
   logic [41:0]     dut_pkt;

   ent_t            mq [N][$];
   int              mrr;
   logic [41:0]     exp_pkt;
   logic [N-1:0]    exp_ready;
   logic [N-1:0]    mdl_acc;

   int              n_tests = 0;
   int              n_fail  = 0;

   for (genvar g = 0; g < N; g++) begin : g_pack
      assign fu_tag[g*TW +: TW]   = tag_in[g];
      assign fu_value[g*XW +: XW] = val_in[g];
   end

   assign dut_pkt = {cdb_no_output, cdb_tag, cdb_tag_valid, cdb_value, cdb_correct_predict, cdb_grant};

   always #5 clock = ~clock;

   cdb_broadcaster #(.NUM_FU(N), .XLEN(XW), .ROB_LEN(32)) dut (
      .clock              (clock),
      .reset              (reset),
      .squash             (squash),
      .fu_valid           (fu_valid),
      .fu_ready           (fu_ready),
      .fu_tag             (fu_tag),
      .fu_value           (fu_value),
      .fu_wb_en           (fu_wb_en),
      .fu_mispredict      (fu_mispredict),
      .cdb_no_output      (cdb_no_output),
      .cdb_tag            (cdb_tag),
      .cdb_tag_valid      (cdb_tag_valid),
      .cdb_value          (cdb_value),
      .cdb_correct_predict(cdb_correct_predict),
      .cdb_grant          (cdb_grant)
   );

   task automatic clear_inputs();
      squash        = 1'b0;
      fu_valid      = '0;
      fu_wb_en      = '0;
      fu_mispredict = '0;
      for (int i = 0; i < N; i++) begin
         tag_in[i] = '0;
         val_in[i] = '0;
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < N; i++) mq[i].delete();
      mrr = 0;
   endtask

   // Advance one clock edge: the model consumes the inputs present before the edge,
   // then the DUT is sampled 1 time unit after the edge.
   task automatic tick();
      int   w;
      ent_t e;
      mdl_acc = '0;
      if (squash) begin
         model_clear();
         exp_pkt = IDLE;
      end else begin
         for (int i = 0; i < N; i++) mdl_acc[i] = fu_valid[i] && (mq[i].size() < 2);
         w = -1;
         for (int off = 0; off < N; off++) begin
            if (w < 0 && mq[(mrr + off) % N].size() > 0) w = (mrr + off) % N;
         end
         if (w >= 0) begin
            e       = mq[w].pop_front();
            exp_pkt = {1'b0, e.tag, e.wb, e.val, ~e.mp, 2'(w)};
            mrr     = (w + 1) % N;
         end else begin
            exp_pkt = IDLE;
         end
         for (int i = 0; i < N; i++) begin
            if (mdl_acc[i]) begin
               e = {tag_in[i], val_in[i], fu_wb_en[i], fu_mispredict[i]};
               mq[i].push_back(e);
            end
         end
      end
      @(posedge clock);
      #1;
      for (int i = 0; i < N; i++) exp_ready[i] = (mq[i].size() < 2);
   endtask

   task automatic test_reset();
      clear_inputs();
      fu_valid = 4'b1111;
      for (int i = 0; i < N; i++) begin
         tag_in[i] = 5'(i + 1);
         val_in[i] = $urandom;
      end
      tick();
      fu_valid = '0;
      tick();
      n_tests++;
      if (dut_pkt !== exp_pkt) begin
         n_fail++;
         $display("FAIL reset_preload pkt got=%h want=%h", dut_pkt, exp_pkt);
      end
      #2 reset = 1'b1;
      #1;
      model_clear();
      n_tests++;
      if (dut_pkt !== IDLE || fu_ready !== 4'b1111) begin
         n_fail++;
         $display("FAIL reset_async pkt=%h ready=%b want pkt=%h ready=1111", dut_pkt, fu_ready, IDLE);
      end
      @(posedge clock);
      #1;
      reset = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         n_tests++;
         if (cdb_no_output !== 1'b1 || cdb_correct_predict !== 1'b1 || fu_ready !== 4'b1111) begin
            n_fail++;
            $display("FAIL reset_idle cyc=%0d no_output=%b correct=%b ready=%b want 1 1 1111",
                     c, cdb_no_output, cdb_correct_predict, fu_ready);
         end
      end
   endtask

   task automatic test_single_latency();
      clear_inputs();
      fu_valid[2] = 1'b1;
      fu_wb_en[2] = 1'b1;
      tag_in[2]   = 5'd5;
      val_in[2]   = 32'hDEADBEEF;
      tick();
      clear_inputs();
      n_tests++;
      if (dut_pkt !== IDLE) begin
         n_fail++;
         $display("FAIL single_no_bypass pkt got=%h want=%h", dut_pkt, IDLE);
      end
      tick();
      n_tests++;
      if (dut_pkt !== {1'b0, 5'd5, 1'b1, 32'hDEADBEEF, 1'b1, 2'd2}) begin
         n_fail++;
         $display("FAIL single_broadcast pkt got=%h want=%h", dut_pkt,
                  {1'b0, 5'd5, 1'b1, 32'hDEADBEEF, 1'b1, 2'd2});
      end
      tick();
      n_tests++;
      if (dut_pkt !== IDLE) begin
         n_fail++;
         $display("FAIL single_after pkt got=%h want=%h", dut_pkt, IDLE);
      end
   endtask

   task automatic test_round_robin();
      logic [XW-1:0] v [N];
      logic [41:0]   want;
      clear_inputs();
      squash = 1'b1;
      tick();
      squash = 1'b0;
      fu_valid = 4'b1111;
      fu_wb_en = 4'b1111;
      for (int i = 0; i < N; i++) begin
         tag_in[i] = 5'(10 + i);
         v[i]      = $urandom;
         val_in[i] = v[i];
      end
      tick();
      clear_inputs();
      for (int i = 0; i < N; i++) begin
         tick();
         want = {1'b0, 5'(10 + i), 1'b1, v[i], 1'b1, 2'(i)};
         n_tests++;
         if (dut_pkt !== want) begin
            n_fail++;
            $display("FAIL rr_order slot=%0d pkt got=%h want=%h", i, dut_pkt, want);
         end
      end
      tick();
      n_tests++;
      if (dut_pkt !== IDLE) begin
         n_fail++;
         $display("FAIL rr_drained pkt got=%h want=%h", dut_pkt, IDLE);
      end
      fu_valid  = 4'b1001;
      tag_in[0] = 5'd14;
      tag_in[3] = 5'd15;
      tick();
      clear_inputs();
      tick();
      n_tests++;
      if (cdb_no_output !== 1'b0 || cdb_grant !== 2'd0 || cdb_tag !== 5'd14) begin
         n_fail++;
         $display("FAIL rr_wrap_first grant=%0d tag=%0d want grant=0 tag=14", cdb_grant, cdb_tag);
      end
      tick();
      n_tests++;
      if (cdb_no_output !== 1'b0 || cdb_grant !== 2'd3 || cdb_tag !== 5'd15) begin
         n_fail++;
         $display("FAIL rr_wrap_second grant=%0d tag=%0d want grant=3 tag=15", cdb_grant, cdb_tag);
      end
   endtask

   task automatic test_backpressure();
      logic [TW-1:0] got1 [$];
      int            k;
      bit            saw_nr;
      clear_inputs();
      k      = 0;
      saw_nr = 0;
      for (int i = 0; i < N; i++) begin
         tag_in[i] = 5'($urandom_range(0, 31));
         val_in[i] = $urandom;
      end
      fu_wb_en  = 4'b1111;
      tag_in[1] = 5'd20;
      for (int c = 0; c < 16; c++) begin
         fu_valid = {1'b1, 1'b1, (k < 3), 1'b1};
         tick();
         if (cdb_no_output === 1'b0 && cdb_grant === 2'd1) got1.push_back(cdb_tag);
         if (fu_ready[1] === 1'b0) saw_nr = 1;
         n_tests++;
         if (dut_pkt !== exp_pkt || fu_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL bp_stream cyc=%0d pkt=%h ready=%b want pkt=%h ready=%b",
                     c, dut_pkt, fu_ready, exp_pkt, exp_ready);
         end
         for (int i = 0; i < N; i++) begin
            if (mdl_acc[i]) begin
               if (i == 1) begin
                  k++;
                  tag_in[1] = 5'(20 + k);
               end else begin
                  tag_in[i] = 5'($urandom_range(0, 31));
               end
               val_in[i] = $urandom;
            end
         end
      end
      fu_valid = '0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (cdb_no_output === 1'b0 && cdb_grant === 2'd1) got1.push_back(cdb_tag);
         n_tests++;
         if (dut_pkt !== exp_pkt || fu_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL bp_drain cyc=%0d pkt=%h ready=%b want pkt=%h ready=%b",
                     c, dut_pkt, fu_ready, exp_pkt, exp_ready);
         end
      end
      n_tests++;
      if (!saw_nr || k != 3) begin
         n_fail++;
         $display("FAIL bp_full saw_not_ready=%0d accepted=%0d want 1 3", saw_nr, k);
      end
      n_tests++;
      if (got1.size() != 3 || got1[0] !== 5'd20 || got1[1] !== 5'd21 || got1[2] !== 5'd22) begin
         n_fail++;
         $display("FAIL bp_unit1_data count=%0d want 3 tags 20,21,22 in order", got1.size());
      end
      clear_inputs();
   endtask

   task automatic test_mispredict();
      logic [XW-1:0] v;
      clear_inputs();
      v                = $urandom;
      fu_valid[0]      = 1'b1;
      fu_mispredict[0] = 1'b1;
      tag_in[0]        = 5'd7;
      val_in[0]        = v;
      tick();
      clear_inputs();
      tick();
      n_tests++;
      if (dut_pkt !== {1'b0, 5'd7, 1'b0, v, 1'b0, 2'd0}) begin
         n_fail++;
         $display("FAIL mispredict pkt got=%h want=%h", dut_pkt, {1'b0, 5'd7, 1'b0, v, 1'b0, 2'd0});
      end
   endtask

   task automatic test_squash();
      clear_inputs();
      fu_valid = 4'b1111;
      fu_wb_en = 4'b1111;
      for (int i = 0; i < N; i++) begin
         tag_in[i] = 5'(i);
         val_in[i] = $urandom;
      end
      for (int c = 1; c <= 3; c++) begin
         tick();
         for (int i = 0; i < N; i++) begin
            if (mdl_acc[i]) tag_in[i] = 5'(c * 4 + i);
         end
      end
      squash = 1'b1;
      for (int i = 0; i < N; i++) tag_in[i] = 5'(24 + i);
      tick();
      clear_inputs();
      n_tests++;
      if (dut_pkt !== IDLE || fu_ready !== 4'b1111) begin
         n_fail++;
         $display("FAIL squash_idle pkt=%h ready=%b want pkt=%h ready=1111", dut_pkt, fu_ready, IDLE);
      end
      for (int c = 0; c < 8; c++) begin
         tick();
         n_tests++;
         if (dut_pkt !== IDLE) begin
            n_fail++;
            $display("FAIL squash_stale cyc=%0d pkt got=%h want=%h", c, dut_pkt, IDLE);
         end
      end
   endtask

   task automatic test_random();
      clear_inputs();
      for (int c = 0; c < 400; c++) begin
         squash = ($urandom_range(0, 24) == 0);
         for (int i = 0; i < N; i++) begin
            if (!fu_valid[i]) begin
               fu_valid[i]      = ($urandom_range(0, 9) < 6);
               tag_in[i]        = 5'($urandom_range(0, 31));
               val_in[i]        = $urandom;
               fu_wb_en[i]      = 1'($urandom_range(0, 1));
               fu_mispredict[i] = (i == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
         end
         tick();
         n_tests++;
         if (dut_pkt !== exp_pkt || fu_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL random cyc=%0d pkt=%h ready=%b want pkt=%h ready=%b",
                     c, dut_pkt, fu_ready, exp_pkt, exp_ready);
         end
         for (int i = 0; i < N; i++) begin
            if (mdl_acc[i]) fu_valid[i] = 1'b0;
         end
      end
      clear_inputs();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_inputs();
      model_clear();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      test_reset();
      test_single_latency();
      test_round_robin();
      test_backpressure();
      test_mispredict();
      test_squash();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
